// File: rtl/p2p_port_demux_pkg.sv
// Shared constants for the P2P ingress demux: entry/head field positions,
// routing mask, and FSM state encoding.
package p2p_port_demux_pkg;

    localparam int INGRESS_QUEUE_WIDTH = 288;
    localparam int C_DATA_WIDTH        = 256;
    localparam int HEAD_WIDTH          = 64;
    localparam int DEV_WIDTH           = 3;
    localparam int LEN_WIDTH           = 16;
    localparam int KEEP_WIDTH          = 5;

    localparam logic [7:0] Q1_DEV_MASK = 8'hF0;

    localparam int START_BIT = 256;
    localparam int END_BIT   = 257;
    localparam int KEEP_LSB  = 258;
    localparam int LEN_LSB   = 263;
    localparam int SRC_LSB   = 279;
    localparam int DST_LSB   = 282;

    localparam int HEAD_DST_LSB = 35;
    localparam int HEAD_SRC_LSB = 32;
    localparam int HEAD_LEN_LSB = 0;

    localparam logic [LEN_WIDTH-1:0] BEAT_BYTES = 16'd32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PKT_Q0 = 2'd1,
        PKT_Q1 = 2'd2
    } state_t;

    // Length 0 wraps to keep=31 through the 16-bit subtract.
    function automatic logic [KEEP_WIDTH-1:0] calc_keep(input logic last,
                                                        input logic [LEN_WIDTH-1:0] rem);
        logic [LEN_WIDTH-1:0] m1;
        m1 = rem - 16'd1;
        return last ? m1[KEEP_WIDTH-1:0] : 5'd31;
    endfunction

endpackage

// File: rtl/p2p_port_demux_entry_pack.sv
// Combinational builder of the 288-bit ingress queue entry.
module p2p_port_demux_entry_pack
    import p2p_port_demux_pkg::*;
(
    input  logic [DEV_WIDTH-1:0]           i_dst,
    input  logic [DEV_WIDTH-1:0]           i_src,
    input  logic [LEN_WIDTH-1:0]           i_len,
    input  logic [KEEP_WIDTH-1:0]          i_keep,
    input  logic                           i_start,
    input  logic                           i_end,
    input  logic [C_DATA_WIDTH-1:0]        i_data,
    output logic [INGRESS_QUEUE_WIDTH-1:0] o_entry
);

    always_comb begin
        o_entry                           = '0;
        o_entry[C_DATA_WIDTH-1:0]         = i_data;
        o_entry[START_BIT]                = i_start;
        o_entry[END_BIT]                  = i_end;
        o_entry[KEEP_LSB +: KEEP_WIDTH]   = i_keep;
        o_entry[LEN_LSB +: LEN_WIDTH]     = i_len;
        o_entry[SRC_LSB +: DEV_WIDTH]     = i_src;
        o_entry[DST_LSB +: DEV_WIDTH]     = i_dst;
    end

endmodule

// File: rtl/p2p_port_demux.sv
// P2P receive stream to two ingress queues, routed per packet by head dst_dev.
// Optional length-mismatch checker enabled by macro P2P_DEMUX_LEN_CHECK_EN.
module p2p_port_demux
    import p2p_port_demux_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           p2p_rx_valid,
    input  logic                           p2p_rx_last,
    input  logic [C_DATA_WIDTH-1:0]        p2p_rx_data,
    input  logic [HEAD_WIDTH-1:0]          p2p_rx_head,
    output logic                           p2p_rx_ready,
    input  logic                           i_queue_0_prog_full,
    output logic                           o_queue_0_wr_en,
    output logic [INGRESS_QUEUE_WIDTH-1:0] ov_queue_0_data,
    input  logic                           i_queue_1_prog_full,
    output logic                           o_queue_1_wr_en,
    output logic [INGRESS_QUEUE_WIDTH-1:0] ov_queue_1_data,
    output logic                           o_len_err,
    output logic [15:0]                    ov_len_err_cnt
);

    state_t                           r_state;
    logic [DEV_WIDTH-1:0]             r_dst;
    logic [DEV_WIDTH-1:0]             r_src;
    logic [LEN_WIDTH-1:0]             r_len;
    logic [LEN_WIDTH-1:0]             r_rem;
    logic                             r_q0_wr_en;
    logic                             r_q1_wr_en;
    logic [INGRESS_QUEUE_WIDTH-1:0]   r_q0_data;
    logic [INGRESS_QUEUE_WIDTH-1:0]   r_q1_data;

    logic                             w_first;
    logic                             w_tgt_q1;
    logic                             w_acc;
    logic [DEV_WIDTH-1:0]             w_head_dst;
    logic [DEV_WIDTH-1:0]             w_dst;
    logic [DEV_WIDTH-1:0]             w_src;
    logic [LEN_WIDTH-1:0]             w_len;
    logic [LEN_WIDTH-1:0]             w_rem;
    logic [LEN_WIDTH-1:0]             w_rem_next;
    logic [KEEP_WIDTH-1:0]            w_keep;
    logic [INGRESS_QUEUE_WIDTH-1:0]   w_entry;
    logic                             w_unused_head;

    assign w_unused_head = ^{p2p_rx_head[HEAD_WIDTH-1:HEAD_DST_LSB+DEV_WIDTH],
                             p2p_rx_head[HEAD_SRC_LSB-1:HEAD_LEN_LSB+LEN_WIDTH]};

    assign w_first    = (r_state == IDLE);
    assign w_head_dst = p2p_rx_head[HEAD_DST_LSB +: DEV_WIDTH];

    // Target is fixed for the whole packet once the first beat is taken.
    assign w_tgt_q1     = w_first ? Q1_DEV_MASK[w_head_dst] : (r_state == PKT_Q1);
    assign p2p_rx_ready = w_tgt_q1 ? !i_queue_1_prog_full : !i_queue_0_prog_full;
    assign w_acc        = p2p_rx_valid && p2p_rx_ready;

    assign w_dst      = w_first ? w_head_dst : r_dst;
    assign w_src      = w_first ? p2p_rx_head[HEAD_SRC_LSB +: DEV_WIDTH] : r_src;
    assign w_len      = w_first ? p2p_rx_head[HEAD_LEN_LSB +: LEN_WIDTH] : r_len;
    assign w_rem      = w_first ? p2p_rx_head[HEAD_LEN_LSB +: LEN_WIDTH] : r_rem;
    assign w_rem_next = (w_rem > BEAT_BYTES) ? (w_rem - BEAT_BYTES) : '0;
    assign w_keep     = calc_keep(p2p_rx_last, w_rem);

    p2p_port_demux_entry_pack u_entry_pack (
        .i_dst   (w_dst),
        .i_src   (w_src),
        .i_len   (w_len),
        .i_keep  (w_keep),
        .i_start (w_first),
        .i_end   (p2p_rx_last),
        .i_data  (p2p_rx_data),
        .o_entry (w_entry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dst      <= '0;
            r_src      <= '0;
            r_len      <= '0;
            r_rem      <= '0;
            r_q0_wr_en <= 1'b0;
            r_q1_wr_en <= 1'b0;
            r_q0_data  <= '0;
            r_q1_data  <= '0;
        end else begin
            r_q0_wr_en <= 1'b0;
            r_q1_wr_en <= 1'b0;
            if (w_acc) begin
                if (w_tgt_q1) begin
                    r_q1_wr_en <= 1'b1;
                    r_q1_data  <= w_entry;
                end else begin
                    r_q0_wr_en <= 1'b1;
                    r_q0_data  <= w_entry;
                end
                r_rem <= w_rem_next;
                if (w_first) begin
                    r_dst <= w_dst;
                    r_src <= w_src;
                    r_len <= w_len;
                end
                if (p2p_rx_last)
                    r_state <= IDLE;
                else
                    r_state <= w_tgt_q1 ? PKT_Q1 : PKT_Q0;
            end
        end
    end

    assign o_queue_0_wr_en = r_q0_wr_en;
    assign o_queue_1_wr_en = r_q1_wr_en;
    assign ov_queue_0_data = r_q0_data;
    assign ov_queue_1_data = r_q1_data;

`ifdef P2P_DEMUX_LEN_CHECK_EN
    logic        r_len_err;
    logic [15:0] r_len_err_cnt;
    logic        w_len_mm;

    assign w_len_mm = p2p_rx_last ? (w_rem > BEAT_BYTES) : (w_rem <= BEAT_BYTES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_err     <= 1'b0;
            r_len_err_cnt <= '0;
        end else if (w_acc && w_len_mm) begin
            r_len_err <= 1'b1;
            if (r_len_err_cnt != 16'hFFFF)
                r_len_err_cnt <= r_len_err_cnt + 16'd1;
        end
    end

    assign o_len_err      = r_len_err;
    assign ov_len_err_cnt = r_len_err_cnt;
`else
    assign o_len_err      = 1'b0;
    assign ov_len_err_cnt = '0;
`endif

endmodule

// File: tb/tb_p2p_port_demux.sv
// Self-checking bench for p2p_port_demux: directed cases plus randomized
// packets/backpressure against a packet-level reference model.
module tb_p2p_port_demux;

    logic         clk = 1'b0;
    logic         rst;
    logic         p2p_rx_valid;
    logic         p2p_rx_last;
    logic [255:0] p2p_rx_data;
    logic [63:0]  p2p_rx_head;
    logic         p2p_rx_ready;
    logic         i_queue_0_prog_full;
    logic         o_queue_0_wr_en;
    logic [287:0] ov_queue_0_data;
    logic         i_queue_1_prog_full;
    logic         o_queue_1_wr_en;
    logic [287:0] ov_queue_1_data;
    logic         o_len_err;
    logic [15:0]  ov_len_err_cnt;

    localparam logic [7:0] TB_Q1_MASK = 8'hF0;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           exp_cnt  = 0;
    logic [287:0] exp_d0   = '0;
    logic [287:0] exp_d1   = '0;

    p2p_port_demux dut (
        .clk                 (clk),
        .rst                 (rst),
        .p2p_rx_valid        (p2p_rx_valid),
        .p2p_rx_last         (p2p_rx_last),
        .p2p_rx_data         (p2p_rx_data),
        .p2p_rx_head         (p2p_rx_head),
        .p2p_rx_ready        (p2p_rx_ready),
        .i_queue_0_prog_full (i_queue_0_prog_full),
        .o_queue_0_wr_en     (o_queue_0_wr_en),
        .ov_queue_0_data     (ov_queue_0_data),
        .i_queue_1_prog_full (i_queue_1_prog_full),
        .o_queue_1_wr_en     (o_queue_1_wr_en),
        .ov_queue_1_data     (ov_queue_1_data),
        .o_len_err           (o_len_err),
        .ov_len_err_cnt      (ov_len_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("q0_wr_en", o_queue_0_wr_en, 1'b0);
        chk("q1_wr_en", o_queue_1_wr_en, 1'b0);
        chk("q0_data", ov_queue_0_data, exp_d0);
        chk("q1_data", ov_queue_1_data, exp_d1);
        chk("len_err", o_len_err, exp_cnt != 0);
        chk("len_err_cnt", ov_len_err_cnt, exp_cnt[15:0]);
    endtask

    // One clock of stimulus; the model decides acceptance from the prog_full it drives.
    task automatic cycle_beat(input logic v, input logic last, input logic [255:0] data,
                              input logic [63:0] head, input logic pf0, input logic pf1,
                              input logic q1, input logic [287:0] entry, input logic mm,
                              output logic acc);
        logic exp_ready;
        @(negedge clk);
        p2p_rx_valid        = v;
        p2p_rx_last         = last;
        p2p_rx_data         = data;
        p2p_rx_head         = head;
        i_queue_0_prog_full = pf0;
        i_queue_1_prog_full = pf1;
        #1;
        exp_ready = q1 ? !pf1 : !pf0;
        chk("ready", p2p_rx_ready, exp_ready);
        acc = v && exp_ready;
        if (acc) begin
            if (q1) exp_d1 = entry;
            else    exp_d0 = entry;
`ifdef P2P_DEMUX_LEN_CHECK_EN
            if (mm && exp_cnt < 65535) exp_cnt++;
`endif
        end
        @(posedge clk);
        #1;
        chk("q0_wr_en", o_queue_0_wr_en, acc && !q1);
        chk("q1_wr_en", o_queue_1_wr_en, acc && q1);
        chk("q0_data", ov_queue_0_data, exp_d0);
        chk("q1_data", ov_queue_1_data, exp_d1);
        chk("len_err", o_len_err, exp_cnt != 0);
        chk("len_err_cnt", ov_len_err_cnt, exp_cnt[15:0]);
    endtask

    // Sends a packet of nbeats beats. rnd: random gaps/backpressure.
    // Directed: target held full for stall_cyc cycles at stall_beat; other queue full = other_pf.
    task automatic send_pkt(input logic [2:0] dst, input logic [2:0] src, input logic [15:0] len,
                            input int nbeats, input logic rnd, input int stall_beat,
                            input int stall_cyc, input logic other_pf);
        logic         q1, last, first, acc, v, pf0, pf1, pf_t, mm;
        logic [255:0] data;
        logic [63:0]  head;
        logic [4:0]   keep;
        logic [287:0] entry;
        logic [7:0]   mask;
        int           rem, n;
        mask = TB_Q1_MASK;
        q1   = mask[dst];
        for (int i = 0; i < nbeats; i++) begin
            rem   = (len > 32 * i) ? (len - 32 * i) : 0;
            last  = (i == nbeats - 1);
            first = (i == 0);
            keep  = last ? 5'((rem - 1) & 31) : 5'd31;
            mm    = last ? (rem > 32) : (rem <= 32);
            for (int k = 0; k < 8; k++) data[32*k +: 32] = $urandom;
            head = {$urandom, $urandom};
            if (first) begin
                head[37:35] = dst;
                head[34:32] = src;
                head[15:0]  = len;
            end
            entry = {3'b000, dst, src, len, keep, last, first, data};
            acc = 1'b0;
            n   = 0;
            while (!acc) begin
                if (rnd) begin
                    v   = ($urandom_range(0, 4) != 0);
                    pf0 = ($urandom_range(0, 3) == 0);
                    pf1 = ($urandom_range(0, 3) == 0);
                    if (n >= 8) begin
                        v = 1'b1; pf0 = 1'b0; pf1 = 1'b0;
                    end
                end else begin
                    v    = 1'b1;
                    pf_t = (i == stall_beat) && (n < stall_cyc);
                    pf0  = q1 ? other_pf : pf_t;
                    pf1  = q1 ? pf_t : other_pf;
                end
                cycle_beat(v, last, data, head, pf0, pf1, q1, entry, mm, acc);
                n++;
            end
        end
    endtask

    initial begin
        logic         acc;
        logic [255:0] d;
        logic [63:0]  h;
        int           len, nb;

        rst = 1'b1;
        p2p_rx_valid = 1'b0; p2p_rx_last = 1'b0;
        p2p_rx_data = '0; p2p_rx_head = '0;
        i_queue_0_prog_full = 1'b0; i_queue_1_prog_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Single beat to queue 0, then 3 beats to queue 1.
        send_pkt(3'd1, 3'd4, 16'd20, 1, 1'b0, -1, 0, 1'b0);
        send_pkt(3'd6, 3'd2, 16'd70, 3, 1'b0, -1, 0, 1'b0);

        // Back-to-back, alternating queues.
        send_pkt(3'd2, 3'd1, 16'd64, 2, 1'b0, -1, 0, 1'b0);
        send_pkt(3'd5, 3'd3, 16'd32, 1, 1'b0, -1, 0, 1'b0);

        // Queue 1 stalls 4 cycles mid-packet, then a q0 packet flows while q1 stays full.
        send_pkt(3'd6, 3'd0, 16'd70, 3, 1'b0, 1, 4, 1'b0);
        send_pkt(3'd0, 3'd7, 16'd40, 2, 1'b0, -1, 0, 1'b1);

        // Length 0 single beat.
        send_pkt(3'd3, 3'd5, 16'd0, 1, 1'b0, -1, 0, 1'b0);

        // Length mismatch: 100 bytes declared, last on second beat.
        send_pkt(3'd4, 3'd1, 16'd100, 2, 1'b0, -1, 0, 1'b0);

        // Reset after the first beat of a 3-beat packet.
        for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
        h = {$urandom, $urandom};
        h[37:35] = 3'd6; h[34:32] = 3'd2; h[15:0] = 16'd70;
        cycle_beat(1'b1, 1'b0, d, h, 1'b0, 1'b0, 1'b1,
                   {3'b000, 3'd6, 3'd2, 16'd70, 5'd31, 1'b0, 1'b1, d}, 1'b0, acc);
        @(negedge clk);
        p2p_rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        exp_d0 = '0; exp_d1 = '0; exp_cnt = 0;
        chk_outputs();
        @(negedge clk);
        rst = 1'b0;
        send_pkt(3'd1, 3'd3, 16'd20, 1, 1'b0, -1, 0, 1'b0);

        // Randomized packets with random gaps and backpressure.
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(0, 300);
            nb  = (len == 0) ? 1 : (len + 31) / 32;
            send_pkt(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'(len), nb,
                     1'b1, -1, 0, 1'b0);
        end

        @(negedge clk);
        p2p_rx_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/p2p_port_demux.md
Name: p2p_port_demux

Overview:
- Ingress-side counterpart of the P2P egress port mux.
- Accepts the P2P receive stream (valid/last/data/head/ready) and selects a target ingress queue per packet from the dst_dev field of the head.
- Repacks each beat into the 288-bit queue entry format and writes it to one of two ingress queues.
- Sits between the PCIe P2P down channel and the host-route ingress queues.

Parameters:
- INGRESS_QUEUE_WIDTH, 288, queue entry width.
- C_DATA_WIDTH, 256, stream data width (32 bytes per beat).
- HEAD_WIDTH, 64, stream head width.
- DEV_WIDTH, 3, src_dev/dst_dev field width.
- Q1_DEV_MASK, 8'hF0, one bit per dst_dev value; bit set routes to queue 1, clear routes to queue 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- p2p_rx_valid  in  1  beat valid
- p2p_rx_last  in  1  last beat of packet
- p2p_rx_data  in  256  beat payload
- p2p_rx_head  in  64  packet head, valid on first beat only: [37:35] dst_dev, [34:32] src_dev, [15:0] byte length
- p2p_rx_ready  out  1  beat accepted when valid&&ready
- i_queue_0_prog_full  in  1  queue 0 near full
- o_queue_0_wr_en  out  1  queue 0 write strobe
- ov_queue_0_data  out  288  queue 0 entry
- i_queue_1_prog_full  in  1  queue 1 near full
- o_queue_1_wr_en  out  1  queue 1 write strobe
- ov_queue_1_data  out  288  queue 1 entry
- o_len_err  out  1  sticky length-mismatch flag
- ov_len_err_cnt  out  16  saturating length-mismatch count

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk.
- Reset values: state=IDLE; o_queue_x_wr_en=0; ov_queue_x_data=0; o_len_err=0; ov_len_err_cnt=0; remaining-byte counter=0.
- Queue entry format:
  - [287:285] 0
  - [284:282] dst_dev
  - [281:279] src_dev
  - [278:263] byte length
  - [262:258] keep = valid bytes in beat minus 1
  - [257] end
  - [256] start
  - [255:0] data
- dst_dev, src_dev and length come from the head captured on the first beat; they are repeated on every entry of the packet.
- States:
  - IDLE: next accepted beat is a first beat.
  - PKT_Q0 / PKT_Q1: body of a packet to that queue.
- Target selection in IDLE: tgt = Q1_DEV_MASK[p2p_rx_head[37:35]]. In PKT_Qx the target is the latched queue.
- p2p_rx_ready = !prog_full of the current target (combinational). prog_full threshold must leave at least 2 entries of slack.
- Accepted beat → registered write to the target queue in the next cycle (latency 1). The other queue's wr_en stays 0. Data registers hold their value when wr_en=0.
- Accepting a first beat:
  - start=1.
  - remaining = length.
  - Next state: PKT_Qtgt, or IDLE if last.
- Every accepted beat:
  - keep = last ? (remaining-1)[4:0] : 31.
  - remaining is decremented by 32 with saturation at 0.
- Accepting a last beat returns the block to IDLE.
- Back-to-back packets are supported: a last beat followed by a first beat on the next cycle needs no bubble. Consecutive packets may alternate queues.
- Length 0: treated as a single 1..32-byte packet, keep=31 (16-bit wrap of remaining-1).
- valid=0 mid-packet: state holds, no write.
- prog_full asserting mid-packet: the stream stalls. The target never changes within a packet.
- Reset mid-packet: the partial packet is dropped, with no end entry written. Upstream must restart on a packet boundary.

Optional Feature:
- Macro P2P_DEMUX_LEN_CHECK_EN.
- With the macro: a length mismatch sets o_len_err (sticky until rst) and increments ov_len_err_cnt (saturating at 16'hFFFF). Mismatch is either of:
  - last beat accepted while remaining > 32 before decrement;
  - non-last beat accepted while remaining <= 32.
  - The packet is still forwarded unchanged.
- Without the macro: o_len_err=0 and ov_len_err_cnt=0 constantly; no check logic is built.

Decomposition:
- Shared package/header (route_params_def.vh):
  - entry field bit positions (START_BIT 256, END_BIT 257, KEEP_LSB 258, LEN_LSB 263, SRC_LSB 279, DST_LSB 282);
  - head field positions;
  - state encodings IDLE/PKT_Q0/PKT_Q1.
- One natural sub-module: p2p_entry_pack. This is a combinational builder of the 288-bit entry from head fields, keep, start, end and data. The FSM, counter and output registers stay in the top module.

Test Plan:
- Single-beat packet, dst_dev=1, length=20 → one queue 0 write with start=1, end=1, keep=19, [278:263]=20, [284:282]=1.
- 3-beat packet, dst_dev=6, length=70 → three queue 1 writes; keep=31,31,5; start only on beat 0; end only on beat 2.
- Back-to-back packets: dst 2 (64 bytes), then dst 5 (32 bytes) with no gap → writes q0,q0,q1 on consecutive cycles; ready stays 1 throughout.
- queue 1 prog_full held high 4 cycles mid-packet → ready=0 for 4 cycles, no writes, then the packet resumes intact. A new dst 0 packet then flows while queue 1 is still full.
- rst asserted after beat 1 of a 3-beat packet → outputs go to 0 immediately and the state is IDLE. The next beat is treated as a first beat.
- With P2P_DEMUX_LEN_CHECK_EN: length=100 sent with last on beat 2 → o_len_err=1, cnt=1, both entries still written. Without the macro, the same stimulus leaves both outputs at 0.
